// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 control sequencer.
// Steps a one-hot T-state ring (T1..T6) and decodes the control word from
// (tstate, opcode). Fetch occupies T1-T3; T4-T6 execute LDA/ADD/SUB/OUT.
// HLT freezes the ring at T4 until CLR or programming mode (prog=0).
//
// Ports:
//   CLK     in   system clock, rising edge
//   CLR     in   asynchronous active-high reset
//   prog    in   1 = run mode, 0 = programming mode
//   opcode  in   [3:0] instruction-register upper nibble
//   tstate  out  [5:0] one-hot T-state, bit0 = T1
//   Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo
//           out  control word, combinational decode (n* are active-low)
//   halted  out  HLT latch
//
// Configuration macro: EARLY_END_EN
//   defined   -> LDA ends after T5, OUT/NOP end after T4
//   undefined -> every non-HLT instruction takes six T-states
module sap1_controller (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       prog,
    input  logic [3:0] opcode,
    output logic [5:0] tstate,
    output logic       Cp,
    output logic       Ep,
    output logic       nLm,
    output logic       nCE,
    output logic       nLi,
    output logic       nEi,
    output logic       nLa,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       nLb,
    output logic       nLo,
    output logic       halted
);

    localparam int unsigned OP_W = 4;
    localparam int unsigned T_W  = 6;

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'b1110);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'b1111);

    typedef enum logic [T_W-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    tstate_e tstate_q, tstate_d;
    logic    halted_q, halted_d;

    logic is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
    logic end_at_t4, end_at_t5;

    // Opcode classification
    always_comb begin
        is_lda = (opcode == OP_LDA);
        is_add = (opcode == OP_ADD);
        is_sub = (opcode == OP_SUB);
        is_out = (opcode == OP_OUT);
        is_hlt = (opcode == OP_HLT);
        is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);
    end

    // Early instruction termination points
`ifdef EARLY_END_EN
    assign end_at_t4 = is_out || is_nop;
    assign end_at_t5 = is_lda;
`else
    assign end_at_t4 = 1'b0;
    assign end_at_t5 = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            tstate_q <= T1;
            halted_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    // Next T-state and HLT latch; programming mode parks at T1 and clears HLT
    always_comb begin
        tstate_d = T1;
        halted_d = 1'b0;
        if (prog) begin
            halted_d = halted_q;
            case (tstate_q)
                T1: tstate_d = T2;
                T2: tstate_d = T3;
                T3: begin
                    tstate_d = T4;
                    if (is_hlt) halted_d = 1'b1;
                end
                T4: begin
                    if (halted_q)       tstate_d = T4;
                    else if (end_at_t4) tstate_d = T1;
                    else                tstate_d = T5;
                end
                T5: tstate_d = end_at_t5 ? T1 : T6;
                T6: tstate_d = T1;
                // Non-one-hot values recover to T1
                default: begin
                    tstate_d = T1;
                    halted_d = 1'b0;
                end
            endcase
        end
    end

    // Control-word decode; inactive during reset, programming mode or halt
    always_comb begin
        Cp  = 1'b0;
        Ep  = 1'b0;
        nLm = 1'b1;
        nCE = 1'b1;
        nLi = 1'b1;
        nEi = 1'b1;
        nLa = 1'b1;
        Ea  = 1'b0;
        Su  = 1'b0;
        Eu  = 1'b0;
        nLb = 1'b1;
        nLo = 1'b1;
        if (!CLR && prog && !halted_q) begin
            case (tstate_q)
                T1: begin
                    Ep  = 1'b1;
                    nLm = 1'b0;
                end
                T2: Cp = 1'b1;
                T3: begin
                    nCE = 1'b0;
                    nLi = 1'b0;
                end
                T4: begin
                    if (is_lda || is_add || is_sub) begin
                        nLm = 1'b0;
                        nEi = 1'b0;
                    end else if (is_out) begin
                        Ea  = 1'b1;
                        nLo = 1'b0;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        nCE = 1'b0;
                        nLa = 1'b0;
                    end else if (is_add || is_sub) begin
                        nCE = 1'b0;
                        nLb = 1'b0;
                    end
                end
                T6: begin
                    if (is_add || is_sub) begin
                        Eu  = 1'b1;
                        nLa = 1'b0;
                        Su  = is_sub;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tstate = T_W'(tstate_q);
    assign halted = halted_q;

endmodule

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: randomized run/program/reset traffic against an
// instruction-level reference model; expected outputs go through a
// scoreboard queue checked by an independent monitor on the falling edge.
module tb_sap1_controller;

    localparam int unsigned NCYC = 4000;
    // Control-word packing: {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
    localparam logic [11:0] INACT = 12'b0011_1110_0011;
    localparam int B_CP = 11, B_EP = 10, B_NLM = 9, B_NCE = 8, B_NLI = 7,
                   B_NEI = 6, B_NLA = 5, B_EA = 4, B_SU = 3, B_EU = 2,
                   B_NLB = 1, B_NLO = 0;

`ifdef EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       CLR;
    logic       prog;
    logic [3:0] opcode;
    logic [5:0] tstate;
    logic Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo;
    logic       halted;

    typedef struct packed {
        logic [5:0]  ts;
        logic [11:0] ctl;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: T-step number 1..6 and halt flag
    int m_t;
    bit m_h;

    sap1_controller dut (
        .CLK(CLK), .CLR(CLR), .prog(prog), .opcode(opcode), .tstate(tstate),
        .Cp(Cp), .Ep(Ep), .nLm(nLm), .nCE(nCE), .nLi(nLi), .nEi(nEi),
        .nLa(nLa), .Ea(Ea), .Su(Su), .Eu(Eu), .nLb(nLb), .nLo(nLo),
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Number of T-states an instruction occupies
    function automatic int instr_len(input logic [3:0] op);
        bit known;
        known = (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd14);
        if (!EARLY)       return 6;
        if (op == 4'd0)   return 5;
        if (op == 4'd1 || op == 4'd2) return 6;
        if (op == 4'd14 || !known)    return 4;
        return 6;
    endfunction

    // Set of asserted micro-operations for a T-step of an instruction
    function automatic logic [11:0] active_set(input int t, input logic [3:0] op);
        logic [11:0] m;
        m = '0;
        case (t)
            1: begin m[B_EP] = 1'b1; m[B_NLM] = 1'b1; end
            2: m[B_CP] = 1'b1;
            3: begin m[B_NCE] = 1'b1; m[B_NLI] = 1'b1; end
            4: if (op <= 4'd2) begin m[B_NLM] = 1'b1; m[B_NEI] = 1'b1; end
               else if (op == 4'd14) begin m[B_EA] = 1'b1; m[B_NLO] = 1'b1; end
            5: if (op == 4'd0) begin m[B_NCE] = 1'b1; m[B_NLA] = 1'b1; end
               else if (op == 4'd1 || op == 4'd2) begin m[B_NCE] = 1'b1; m[B_NLB] = 1'b1; end
            6: if (op == 4'd1 || op == 4'd2) begin
                   m[B_EU] = 1'b1; m[B_NLA] = 1'b1; m[B_SU] = (op == 4'd2);
               end
            default: ;
        endcase
        return m;
    endfunction

    // Advance the model across one clock edge with the inputs held during it
    task automatic model_edge();
        if (CLR || !prog) begin
            m_t = 1;
            m_h = 1'b0;
        end else if (!m_h) begin
            if (m_t == 3 && opcode == 4'd15) begin
                m_h = 1'b1;
                m_t = 4;
            end else if (m_t >= instr_len(opcode)) begin
                m_t = 1;
            end else begin
                m_t = m_t + 1;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.ts  = 6'(1 << (m_t - 1));
        e.hlt = m_h;
        if (CLR || !prog || m_h) e.ctl = INACT;
        else                     e.ctl = INACT ^ active_set(m_t, opcode);
        exp_q.push_back(e);
    endtask

    function automatic logic [3:0] pick_opcode();
        case ($urandom_range(0, 9))
            0, 1:    return 4'd0;
            2, 3:    return 4'd1;
            4, 5:    return 4'd2;
            6:       return 4'd14;
            7:       return 4'd15;
            8:       return 4'd5;
            default: return 4'($urandom_range(3, 13));
        endcase
    endfunction

    // Stimulus and model
    initial begin
        CLR    = 1'b1;
        prog   = 1'b0;
        opcode = 4'd0;
        m_t    = 1;
        m_h    = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge CLK);
            model_edge();
            #1;
            if (c < 2) begin
                CLR  = 1'b0;
                prog = 1'b1;
            end else begin
                CLR  = ($urandom_range(0, 59) == 0);
                prog = ($urandom_range(0, 11) != 0);
                if ($urandom_range(0, 3) == 0) opcode = pick_opcode();
            end
            if (CLR) m_t = 1;
            if (CLR) m_h = 1'b0;
            push_expected();
        end
        @(negedge CLK);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor: compare DUT outputs against the scoreboard head
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                exp_t e;
                logic [11:0] act;
                bit bad;
                e   = exp_q.pop_front();
                act = {Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo};
                bad = 1'b0;
                vectors++;
                if (tstate !== e.ts) begin
                    bad = 1'b1;
                    $display("FAIL tstate @%0t: got %b required %b (prog=%b op=%h)",
                             $time, tstate, e.ts, prog, opcode);
                end
                if (act !== e.ctl) begin
                    bad = 1'b1;
                    $display("FAIL ctl @%0t: got %b required %b (ts=%b op=%h)",
                             $time, act, e.ctl, tstate, opcode);
                end
                if (halted !== e.hlt) begin
                    bad = 1'b1;
                    $display("FAIL halted @%0t: got %b required %b", $time, halted, e.hlt);
                end
                if (bad) miscompares++;
            end
        end
    end

endmodule

// File: doc/sap1_controller.md
SAP1_CONTROLLER -- requirements
Module: sap1_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: CLK  in  1  system clock, all state updates on rising edge.
REQ-002 The block SHALL have port CLR  in  1  asynchronous active-high reset.
REQ-003 The block SHALL have port prog  in  1  mode select: 1 = run mode, 0 = programming mode.
REQ-004 The block SHALL have port opcode  in  4  instruction-register upper nibble.
REQ-005 The block SHALL have port tstate  out  6  one-hot T-state, bit0 = T1 ... bit5 = T6.
REQ-006 The block SHALL have control-word outputs, each 1-bit, with these inactive values: Cp=0 (PC increment), Ep=0 (PC enable to bus), nLm=1 (MAR load, low-active), nCE=1 (RAM enable to bus), nLi=1 (IR load), nEi=1 (IR address to bus), nLa=1 (A load), Ea=0 (A to bus), Su=0 (subtract), Eu=0 (ALU to bus), nLb=1 (B load), nLo=1 (output register load).
REQ-007 The block SHALL have port halted  out  1  high while the HLT latch is set.

Function
REQ-008 The T-state register SHALL advance one state per rising CLK edge, T1->T2->...->T6->T1, while prog=1 and halted=0.
REQ-009 Control outputs SHALL be combinational decodes of (tstate, opcode); any state/opcode pair not listed SHALL drive the inactive values of REQ-006.
REQ-010 Fetch: T1 Ep=1, nLm=0; T2 Cp=1; T3 nCE=0, nLi=0 (identical for every opcode).
REQ-011 LDA (0000): T4 nLm=0, nEi=0; T5 nCE=0, nLa=0; T6 inactive.
REQ-012 ADD (0001): T4 nLm=0, nEi=0; T5 nCE=0, nLb=0; T6 Eu=1, nLa=0, Su=0.
REQ-013 SUB (0010): as ADD, except Su=1 during T6.
REQ-014 OUT (1110): T4 Ea=1, nLo=0; T5, T6 inactive.
REQ-015 HLT (1111): on the rising edge that exits T3 with opcode=1111, the HLT latch SHALL set and tstate SHALL freeze at T4; all controls inactive while halted.
REQ-016 Undefined opcodes SHALL execute as NOP: T4-T6 inactive, then return to T1.
REQ-017 halted SHALL clear only on CLR or on prog=0.
REQ-018 With prog=0, on each rising edge tstate SHALL load T1 and the HLT latch SHALL clear; all control outputs SHALL be inactive regardless of tstate/opcode.
REQ-019 On prog 0->1, the first run-mode edge SHALL advance T1->T2, so T1 outputs are visible for exactly one cycle before it.
REQ-020 prog falling mid-instruction SHALL abort the instruction: controls go inactive combinationally, and tstate=T1 after the next edge.
REQ-021 tstate SHALL always be one-hot; any non-one-hot value SHALL be forced to T1 on the next edge.

Reset
REQ-022 CLR=1 SHALL immediately, independent of CLK, set tstate=000001 (T1) and clear the HLT latch (halted=0).
REQ-023 While CLR=1, all control outputs SHALL be inactive per REQ-006, including the T1 fetch controls.
REQ-024 After CLR deasserts, the first rising edge with prog=1 SHALL advance to T2.

Configuration
REQ-025 Macro EARLY_END_EN SHALL select variable-length instruction cycles.
REQ-026 With EARLY_END_EN defined: LDA SHALL return T5->T1, skipping T6; OUT and NOP SHALL return T4->T1; ADD and SUB keep 6 states.
REQ-027 With EARLY_END_EN undefined: every non-HLT instruction SHALL take exactly 6 states.

Verification
REQ-028 CLR pulse, prog=1, opcode=0000, 6 edges -> tstate 000010,000100,...,000001; T1 Ep=1/nLm=0, T5 nCE=0/nLa=0, T6 all inactive.
REQ-029 opcode=0010 at T6 -> Eu=1, nLa=0, Su=1; opcode=0001 at T6 -> Su=0.
REQ-030 opcode=1111 through T3 -> halted=1, tstate frozen at 001000 for 10 edges, controls inactive; prog=0 for one edge -> halted=0, tstate=000001.
REQ-031 prog dropped at T5 of ADD -> nCE and nLb return to 1 immediately; tstate=000001 after the next edge; stays T1 while prog=0.
REQ-032 EARLY_END_EN defined, opcode=1110 -> T1..T4 then T1 (4-cycle loop); undefined -> 6-cycle loop; opcode=0101 behaves as a NOP with the matching length.
REQ-033 CLR asserted asynchronously mid-T4 between edges -> tstate=000001 and all controls inactive before the next CLK edge.
